// File: rtl/sab_pkg.sv
// Shared types, defaults and ROB-age helpers for the store address buffer.
package sab_pkg;

  localparam int unsigned SAB_DEPTH   = 8;
  localparam int unsigned SAB_NSCAN   = 8;
  localparam int unsigned SAB_AW      = 32;
  localparam int unsigned SAB_RW      = 5;
  localparam int unsigned SAB_SBW     = 2;
  localparam int unsigned SAB_IGN_LSB = 2;

  // Age arithmetic is done at this width; RW must not exceed it.
  localparam int unsigned SAB_RW_MAX  = 16;

  typedef logic [SAB_RW_MAX-1:0] sab_rob_t;

  // Entry layout for the default configuration.
  typedef struct packed {
    logic                   valid;
    logic                   tsel;
    logic [SAB_AW-1:0]      addr;
    logic [SAB_RW-1:0]      rob;
    logic [SAB_SBW-1:0]     sbtag;
  } sab_entry_t;

  // Distance of a ROB tag from the ROB head, modulo 2^rw.
  function automatic sab_rob_t sab_dist(input sab_rob_t x, input sab_rob_t top,
                                        input int unsigned rw);
    sab_rob_t mask;
    mask = sab_rob_t'((32'd1 << rw) - 32'd1);
    return (x - top) & mask;
  endfunction

  // A committed store is always older than any in-flight load.
  function automatic logic sab_older(input logic committed, input sab_rob_t d_store,
                                     input sab_rob_t d_load);
    return committed | (d_store < d_load);
  endfunction

endpackage

// File: rtl/sab_match_port.sv
// One LSQ scan port: counts matching older stores and picks the youngest one's ROB tag.
module sab_match_port
  import sab_pkg::*;
#(
  parameter int unsigned DEPTH   = SAB_DEPTH,
  parameter int unsigned AW      = SAB_AW,
  parameter int unsigned RW      = SAB_RW,
  parameter int unsigned IGN_LSB = SAB_IGN_LSB,
  parameter int unsigned CW      = $clog2(DEPTH + 1)
) (
  input  logic [DEPTH-1:0]    i_live,
  input  logic [DEPTH-1:0]    i_tsel,
  input  logic [DEPTH*AW-1:0] i_addr,
  input  logic [DEPTH*RW-1:0] i_rob,
  input  logic [RW-1:0]       i_top,
  input  logic [AW-1:0]       i_scan_addr,
  input  logic [RW-1:0]       i_scan_rob,
  output logic [CW-1:0]       o_num_c,
  output logic [RW-1:0]       o_rob_c
);

  logic [DEPTH-1:0] w_hit;
  sab_rob_t         w_load_dist;

  always_comb begin
    w_load_dist = sab_dist(sab_rob_t'(i_scan_rob), sab_rob_t'(i_top), RW);
    for (int i = 0; i < DEPTH; i++) begin
      w_hit[i] = i_live[i]
               & (i_addr[i*AW+IGN_LSB +: AW-IGN_LSB] == i_scan_addr[AW-1:IGN_LSB])
               & sab_older(i_tsel[i],
                           sab_dist(sab_rob_t'(i_rob[i*RW +: RW]), sab_rob_t'(i_top), RW),
                           w_load_dist);
    end
  end

  // Higher index is younger, so the last hit wins the tag.
  always_comb begin
    o_num_c = '0;
    o_rob_c = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_hit[i]) begin
        o_num_c = o_num_c + CW'(1);
        o_rob_c = i_rob[i*RW +: RW];
      end
    end
  end

endmodule

// File: rtl/store_addr_buf_p.sv
// Store address buffer: collapsing queue of issued store addresses with per-port
// older-store match counting for LSQ load scans.
module store_addr_buf_p
  import sab_pkg::*;
#(
  parameter  int unsigned DEPTH   = SAB_DEPTH,
  parameter  int unsigned NSCAN   = SAB_NSCAN,
  parameter  int unsigned AW      = SAB_AW,
  parameter  int unsigned RW      = SAB_RW,
  parameter  int unsigned SBW     = SAB_SBW,
  parameter  int unsigned IGN_LSB = SAB_IGN_LSB,
  localparam int unsigned CW      = $clog2(DEPTH + 1)
) (
  input  logic                Clk,
  input  logic                Resetb,
  input  logic                Lsq_SwValid,
  input  logic [AW-1:0]       Lsq_SwAddr,
  input  logic [RW-1:0]       Lsq_SwRob,
  output logic                Sab_Full,
  output logic [CW-1:0]       Sab_Count,
  input  logic [NSCAN*AW-1:0] Lsq_ScanAddr,
  input  logic [NSCAN*RW-1:0] Lsq_ScanRob,
  output logic [NSCAN-1:0]    Sab_Match,
  output logic [NSCAN*CW-1:0] Sab_MatchNum,
  output logic [NSCAN*RW-1:0] Sab_MatchRob,
  input  logic                Cdb_Flush,
  input  logic [RW-1:0]       Cdb_RobDepth,
  input  logic [RW-1:0]       Rob_TopPtr,
  input  logic                Rob_CommitMemWrite,
  input  logic [SBW-1:0]      SB_TagCounter,
  input  logic                SB_FlushSw,
  input  logic [SBW-1:0]      SB_FlushSwTag
);

  typedef struct packed {
    logic           valid;
    logic           tsel;
    logic [AW-1:0]  addr;
    logic [RW-1:0]  rob;
    logic [SBW-1:0] sbtag;
  } entry_t;

  entry_t              r_ent [DEPTH];
  entry_t              w_nxt [DEPTH];
  logic [CW-1:0]       r_count;
  logic [CW-1:0]       w_count_nxt;
  logic [DEPTH-1:0]    w_flush;
  logic [DEPTH-1:0]    w_leave;
  logic [DEPTH-1:0]    w_live;
  logic [DEPTH-1:0]    w_sh;
  logic [DEPTH-1:0]    w_scan_ok;
  logic [DEPTH-1:0]    w_tsel;
  logic [DEPTH*AW-1:0] w_addr_flat;
  logic [DEPTH*RW-1:0] w_rob_flat;

  // Per-entry flush, SB departure and liveness for this cycle.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_flush[i] = Cdb_Flush & r_ent[i].valid & ~r_ent[i].tsel
                 & (sab_dist(sab_rob_t'(r_ent[i].rob), sab_rob_t'(Rob_TopPtr), RW)
                    > sab_rob_t'(Cdb_RobDepth));
      w_leave[i] = r_ent[i].valid & r_ent[i].tsel & SB_FlushSw
                 & (r_ent[i].sbtag == SB_FlushSwTag);
      w_live[i]  = r_ent[i].valid & ~w_flush[i];
    end
  end

  // A hole or departure at or below i pulls everything above it down one slot.
  always_comb begin
    w_sh[0] = ~w_live[0] | w_leave[0];
    for (int i = 1; i < DEPTH; i++) begin
      w_sh[i] = w_sh[i-1] | ~w_live[i] | w_leave[i];
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_nxt[i] = r_ent[i];
    end
    for (int i = 0; i < DEPTH - 1; i++) begin
      if (w_sh[i]) begin
        w_nxt[i]       = r_ent[i+1];
        w_nxt[i].valid = w_live[i+1] & ~w_leave[i+1];
      end else begin
        w_nxt[i].valid = w_live[i] & ~w_leave[i];
      end
    end
    if (w_sh[DEPTH-2]) begin
      w_nxt[DEPTH-1].valid = 1'b0;
    end else begin
      w_nxt[DEPTH-1].valid = w_live[DEPTH-1] & ~w_leave[DEPTH-1];
    end
    // Commit marks the head store wherever it lands this edge.
    for (int i = 0; i < DEPTH; i++) begin
      if (w_nxt[i].valid & ~w_nxt[i].tsel & Rob_CommitMemWrite
          & (w_nxt[i].rob == Rob_TopPtr)) begin
        w_nxt[i].tsel  = 1'b1;
        w_nxt[i].sbtag = SB_TagCounter;
      end
    end
    if (Lsq_SwValid) begin
      w_nxt[DEPTH-1].valid = 1'b1;
      w_nxt[DEPTH-1].tsel  = 1'b0;
      w_nxt[DEPTH-1].addr  = Lsq_SwAddr;
      w_nxt[DEPTH-1].rob   = Lsq_SwRob;
      w_nxt[DEPTH-1].sbtag = '0;
    end
  end

  always_comb begin
    w_count_nxt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_count_nxt = w_count_nxt + CW'(w_nxt[i].valid);
    end
  end

  always_ff @(posedge Clk or negedge Resetb) begin
    if (!Resetb) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_ent[i] <= '0;
      end
      r_count <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        r_ent[i] <= w_nxt[i];
      end
      r_count <= w_count_nxt;
    end
  end

  assign Sab_Full  = (&w_live) & ~SB_FlushSw;
  assign Sab_Count = r_count;

  // Entries leaving for good this cycle are hidden from scans already.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_addr_flat[i*AW +: AW] = r_ent[i].addr;
      w_rob_flat[i*RW +: RW]  = r_ent[i].rob;
      w_scan_ok[i]            = w_live[i] & ~w_leave[i];
      w_tsel[i]               = r_ent[i].tsel;
    end
  end

  for (genvar k = 0; k < NSCAN; k++) begin : g_scan
    logic [CW-1:0] w_num;
    logic [RW-1:0] w_rob;

    sab_match_port #(
      .DEPTH   (DEPTH),
      .AW      (AW),
      .RW      (RW),
      .IGN_LSB (IGN_LSB),
      .CW      (CW)
    ) u_port (
      .i_live      (w_scan_ok),
      .i_tsel      (w_tsel),
      .i_addr      (w_addr_flat),
      .i_rob       (w_rob_flat),
      .i_top       (Rob_TopPtr),
      .i_scan_addr (Lsq_ScanAddr[k*AW +: AW]),
      .i_scan_rob  (Lsq_ScanRob[k*RW +: RW]),
      .o_num_c     (w_num),
      .o_rob_c     (w_rob)
    );

    assign Sab_MatchNum[k*CW +: CW] = w_num;
    assign Sab_MatchRob[k*RW +: RW] = w_rob;
    assign Sab_Match[k]             = |w_num;
  end

endmodule

// File: tb/tb_store_addr_buf_p.sv
// Bench for store_addr_buf_p: ordered-queue reference model checked every cycle,
// plus hand-computed expectations along the directed scenario.
module tb_store_addr_buf_p;
  import sab_pkg::*;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned NSCAN = 8;
  localparam int unsigned AW    = 32;
  localparam int unsigned RW    = 5;
  localparam int unsigned SBW   = 2;
  localparam int unsigned CW    = 4;

  logic                Clk = 1'b0;
  logic                Resetb = 1'b0;
  logic                Lsq_SwValid;
  logic [AW-1:0]       Lsq_SwAddr;
  logic [RW-1:0]       Lsq_SwRob;
  logic                Sab_Full;
  logic [CW-1:0]       Sab_Count;
  logic [NSCAN*AW-1:0] Lsq_ScanAddr;
  logic [NSCAN*RW-1:0] Lsq_ScanRob;
  logic [NSCAN-1:0]    Sab_Match;
  logic [NSCAN*CW-1:0] Sab_MatchNum;
  logic [NSCAN*RW-1:0] Sab_MatchRob;
  logic                Cdb_Flush;
  logic [RW-1:0]       Cdb_RobDepth;
  logic [RW-1:0]       Rob_TopPtr;
  logic                Rob_CommitMemWrite;
  logic [SBW-1:0]      SB_TagCounter;
  logic                SB_FlushSw;
  logic [SBW-1:0]      SB_FlushSwTag;

  logic [AW-1:0] scan_a [NSCAN];
  logic [RW-1:0] scan_r [NSCAN];

  always_comb begin
    for (int k = 0; k < NSCAN; k++) begin
      Lsq_ScanAddr[k*AW +: AW] = scan_a[k];
      Lsq_ScanRob[k*RW +: RW]  = scan_r[k];
    end
  end

  always #5 Clk = ~Clk;

  store_addr_buf_p #(
    .DEPTH(DEPTH), .NSCAN(NSCAN), .AW(AW), .RW(RW), .SBW(SBW), .IGN_LSB(2)
  ) dut (
    .Clk                (Clk),
    .Resetb             (Resetb),
    .Lsq_SwValid        (Lsq_SwValid),
    .Lsq_SwAddr         (Lsq_SwAddr),
    .Lsq_SwRob          (Lsq_SwRob),
    .Sab_Full           (Sab_Full),
    .Sab_Count          (Sab_Count),
    .Lsq_ScanAddr       (Lsq_ScanAddr),
    .Lsq_ScanRob        (Lsq_ScanRob),
    .Sab_Match          (Sab_Match),
    .Sab_MatchNum       (Sab_MatchNum),
    .Sab_MatchRob       (Sab_MatchRob),
    .Cdb_Flush          (Cdb_Flush),
    .Cdb_RobDepth       (Cdb_RobDepth),
    .Rob_TopPtr         (Rob_TopPtr),
    .Rob_CommitMemWrite (Rob_CommitMemWrite),
    .SB_TagCounter      (SB_TagCounter),
    .SB_FlushSw         (SB_FlushSw),
    .SB_FlushSwTag      (SB_FlushSwTag)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  // Reference model: stores in program order, oldest first; no physical slots.
  sab_entry_t q[$];
  sab_entry_t nq[$];

  function automatic logic [RW-1:0] age(input logic [RW-1:0] x);
    return x - Rob_TopPtr;
  endfunction

  function automatic bit is_flushed(input sab_entry_t e);
    return Cdb_Flush && !e.tsel && (age(e.rob) > Cdb_RobDepth);
  endfunction

  function automatic bit is_leaving(input sab_entry_t e);
    return e.tsel && SB_FlushSw && (e.sbtag == SB_FlushSwTag);
  endfunction

  always @(posedge Clk) begin
    if (!Resetb) begin
      q.delete();
    end else begin
      sab_entry_t e;
      nq.delete();
      foreach (q[j]) begin
        if (!is_flushed(q[j]) && !is_leaving(q[j])) begin
          e = q[j];
          if (!e.tsel && Rob_CommitMemWrite && e.rob == Rob_TopPtr) begin
            e.tsel  = 1'b1;
            e.sbtag = SB_TagCounter;
          end
          nq.push_back(e);
        end
      end
      if (Lsq_SwValid) begin
        e       = '0;
        e.valid = 1'b1;
        e.addr  = Lsq_SwAddr;
        e.rob   = Lsq_SwRob;
        nq.push_back(e);
      end
      q = nq;
    end
  end

  always @(negedge Clk) begin
    if (Resetb) begin
      int            cnt;
      logic [RW-1:0] yr;
      bit            all_live;
      all_live = (q.size() == DEPTH);
      foreach (q[j]) if (is_flushed(q[j])) all_live = 0;
      chk("full", Sab_Full, all_live && !SB_FlushSw);
      chk("count", Sab_Count, q.size());
      if (Lsq_SwValid) chk("insert_while_full", Sab_Full, 0);
      for (int k = 0; k < NSCAN; k++) begin
        cnt = 0;
        yr  = '0;
        foreach (q[j]) begin
          if (!is_flushed(q[j]) && !is_leaving(q[j])
              && q[j].addr[AW-1:2] == scan_a[k][AW-1:2]
              && (q[j].tsel || age(q[j].rob) < age(scan_r[k]))) begin
            cnt++;
            yr = q[j].rob;
          end
        end
        chk($sformatf("matchnum_p%0d", k), Sab_MatchNum[k*CW +: CW], cnt);
        chk($sformatf("matchrob_p%0d", k), Sab_MatchRob[k*RW +: RW], yr);
        chk($sformatf("match_p%0d", k), Sab_Match[k], cnt != 0);
      end
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
    Lsq_SwValid        = 1'b0;
    Cdb_Flush          = 1'b0;
    Rob_CommitMemWrite = 1'b0;
    SB_FlushSw         = 1'b0;
  endtask

  task automatic ins(input logic [AW-1:0] a, input logic [RW-1:0] r);
    Lsq_SwValid = 1'b1;
    Lsq_SwAddr  = a;
    Lsq_SwRob   = r;
  endtask

  initial begin
    Lsq_SwValid = 0; Lsq_SwAddr = '0; Lsq_SwRob = '0;
    Cdb_Flush = 0; Cdb_RobDepth = '0; Rob_TopPtr = '0; Rob_CommitMemWrite = 0;
    SB_TagCounter = '0; SB_FlushSw = 0; SB_FlushSwTag = '0;
    scan_a = '{32'h100, 32'h100, 32'h107, 32'h108, 32'h400, 32'h700, 32'h200, 32'h204};
    scan_r = '{5'd6, 5'd4, 5'd7, 5'd7, 5'd2, 5'd5, 5'd12, 5'd9};

    repeat (2) @(posedge Clk);
    #1;
    chk("rst_full", Sab_Full, 0);
    chk("rst_count", Sab_Count, 0);
    chk("rst_match", Sab_Match, 0);
    chk("rst_num", Sab_MatchNum, 0);
    chk("rst_rob", Sab_MatchRob, 0);
    Resetb = 1'b1;

    // Three stores to 0x100, head at 0.
    ins(32'h100, 5'd3); tick();
    ins(32'h100, 5'd4); tick();
    ins(32'h100, 5'd5); tick();
    #1;
    chk("a_num_p0", Sab_MatchNum[3:0], 3);
    chk("a_rob_p0", Sab_MatchRob[4:0], 5);
    chk("a_num_p1", Sab_MatchNum[7:4], 1);
    chk("a_rob_p1", Sab_MatchRob[9:5], 3);
    chk("a_count", Sab_Count, 3);

    // Low address bits ignored.
    ins(32'h104, 5'd6); tick();
    #1;
    chk("b_num_p2", Sab_MatchNum[11:8], 1);
    chk("b_rob_p2", Sab_MatchRob[14:10], 6);
    chk("b_num_p3", Sab_MatchNum[15:12], 0);
    chk("b_match_p3", Sab_Match[3], 0);

    // Commit rob 3 then fill to full.
    Rob_TopPtr = 5'd3; Rob_CommitMemWrite = 1; SB_TagCounter = 2'd1;
    ins(32'h200, 5'd7); tick();
    ins(32'h204, 5'd8); tick();
    ins(32'h208, 5'd9); tick();
    ins(32'h20C, 5'd10); tick();
    #1;
    chk("c_full", Sab_Full, 1);
    chk("c_count", Sab_Count, 8);
    chk("c_num_p6", Sab_MatchNum[27:24], 1);
    chk("c_rob_p6", Sab_MatchRob[34:30], 7);
    SB_FlushSw = 1; SB_FlushSwTag = 2'd1;
    ins(32'h300, 5'd11);
    #1;
    chk("c_full_drop", Sab_Full, 0);
    tick();
    #1;
    chk("c_count_after", Sab_Count, 8);
    chk("c_full_again", Sab_Full, 1);

    // Flush everything uncommitted, then the wrap-around scenario.
    Rob_TopPtr = 5'd30; Cdb_Flush = 1; Cdb_RobDepth = 5'd0;
    #1;
    chk("d_full_flush", Sab_Full, 0);
    chk("d_num_p6_flush", Sab_MatchNum[27:24], 0);
    tick();
    #1;
    chk("d_count_empty", Sab_Count, 0);
    ins(32'h400, 5'd31); tick();
    ins(32'h404, 5'd0);  tick();
    ins(32'h408, 5'd1);  tick();
    #1;
    chk("d_count3", Sab_Count, 3);
    Cdb_Flush = 1; Cdb_RobDepth = 5'd1;
    #1;
    chk("d_num_p4", Sab_MatchNum[19:16], 1);
    chk("d_rob_p4", Sab_MatchRob[24:20], 31);
    tick();
    #1;
    chk("d_count1", Sab_Count, 1);

    // Commit rob 31 while it is still collapsing downward.
    Rob_TopPtr = 5'd31; Rob_CommitMemWrite = 1; SB_TagCounter = 2'd2;
    scan_r[4] = 5'd31;
    tick();
    #1;
    chk("e_count", Sab_Count, 1);
    chk("e_num_p4", Sab_MatchNum[19:16], 1);
    chk("e_rob_p4", Sab_MatchRob[24:20], 31);

    // Insert, flush and leave in one cycle.
    ins(32'h700, 5'd0); tick();
    ins(32'h700, 5'd1); tick();
    ins(32'h704, 5'd2); tick();
    ins(32'h700, 5'd3);
    Cdb_Flush = 1; Cdb_RobDepth = 5'd1; SB_FlushSw = 1; SB_FlushSwTag = 2'd2;
    #1;
    chk("f_num_p5", Sab_MatchNum[23:20], 1);
    chk("f_rob_p5", Sab_MatchRob[29:25], 0);
    chk("f_num_p4_leave", Sab_MatchNum[19:16], 0);
    tick();
    #1;
    chk("f_count", Sab_Count, 2);
    chk("f_num_p5_after", Sab_MatchNum[23:20], 2);
    chk("f_rob_p5_after", Sab_MatchRob[29:25], 3);

    repeat (10) tick();

    // Reset in the middle of operation.
    ins(32'h900, 5'd4); tick();
    Resetb = 1'b0;
    #1;
    chk("r_count", Sab_Count, 0);
    chk("r_full", Sab_Full, 0);
    chk("r_num_p5", Sab_MatchNum[23:20], 0);
    repeat (2) tick();
    Resetb = 1'b1;
    ins(32'h700, 5'd4); tick();
    #1;
    chk("r_num_p5_new", Sab_MatchNum[23:20], 1);
    chk("r_rob_p5_new", Sab_MatchRob[29:25], 4);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
